// File: rtl/ram_burst_reader_if.sv
// Bundles the burst request, RAM command/data and read-stream signals of ram_burst_reader.
// The master modport is the reader's view; slave is the environment (requester, RAM, consumer).
interface ram_burst_reader_if;
  logic        start;
  logic [31:0] start_addr;
  logic [7:0]  len;
  logic        abort;
  logic        busy;
  logic        ram_enable;
  logic [1:0]  ram_rw;
  logic [31:0] ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic        rd_last;
  logic        done;
  logic        err;

  modport master (
    input  start, start_addr, len, abort, ram_dout, rd_ready,
    output busy, ram_enable, ram_rw, ram_addr, ram_din, rd_data, rd_valid, rd_last, done, err
  );

  modport slave (
    output start, start_addr, len, abort, ram_dout, rd_ready,
    input  busy, ram_enable, ram_rw, ram_addr, ram_din, rd_data, rd_valid, rd_last, done, err
  );
endinterface

// File: rtl/ram_burst_reader.sv
// Reads a burst of words from a fixed-latency RAM, one word in flight, into a valid/ready stream.
// Define RAM_BURST_READER_WRAP_EN to wrap addresses past DEPTH-1 instead of rejecting such bursts.
module ram_burst_reader #(
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned READ_LAT = 1
) (
  input logic               clk,
  input logic               rst_n,
  ram_burst_reader_if.master bus
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StOut, StFin} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [2:0]  lat_q, lat_d;
  logic        err_q, err_d;
  logic        bad_start;
  logic [31:0] next_addr;

  always_comb begin
    bad_start = (bus.start_addr >= 32'(DEPTH));
`ifdef RAM_BURST_READER_WRAP_EN
    next_addr = (addr_q == 32'(DEPTH - 1)) ? 32'd0 : addr_q + 32'd1;
`else
    // 33-bit sum so a huge start address cannot overflow past the check
    if (({1'b0, bus.start_addr} + {25'd0, bus.len}) > 33'(DEPTH)) begin
      bad_start = 1'b1;
    end
    next_addr = addr_q + 32'd1;
`endif
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    err_d   = 1'b0;
    if (state_q != StIdle && bus.abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            if (bad_start) begin
              err_d = 1'b1;
            end else if (bus.len == 8'd0) begin
              state_d = StFin;
            end else begin
              addr_d  = bus.start_addr;
              cnt_d   = {1'b0, bus.len};
              state_d = StReq;
            end
          end
        end
        StReq: begin
          lat_d   = 3'd0;
          state_d = StWait;
        end
        StWait: begin
          if (lat_q == 3'(READ_LAT - 1)) begin
            data_d  = bus.ram_dout;
            state_d = StOut;
          end else begin
            lat_d = lat_q + 3'd1;
          end
        end
        StOut: begin
          if (bus.rd_ready) begin
            if (cnt_q == 9'd1) begin
              state_d = StFin;
            end else begin
              addr_d  = next_addr;
              cnt_d   = cnt_q - 9'd1;
              state_d = StReq;
            end
          end
        end
        StFin:   state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= 32'd0;
      data_q  <= 32'd0;
      cnt_q   <= 9'd0;
      lat_q   <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    bus.busy       = (state_q != StIdle);
    bus.ram_enable = (state_q == StReq);
    bus.ram_rw     = (state_q == StReq) ? 2'b01 : 2'b00;
    bus.ram_addr   = addr_q;
    bus.ram_din    = 32'd0;
    bus.rd_data    = data_q;
    bus.rd_valid   = (state_q == StOut);
    bus.rd_last    = (state_q == StOut) && (cnt_q == 9'd1);
    bus.done       = (state_q == StFin);
    bus.err        = err_q;
  end

endmodule
